// File: rtl/usr_serial_byte_receiver.sv
// Serial-to-parallel receiver for a universal shift register's serial output stream.
// Optional even-parity bit after each word: define USR_RX_PARITY_CHECK_EN.
module usr_serial_byte_receiver #(
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic                  Shift_Direction_In,
  input  logic                  Serial_Valid_In,
  input  logic                  Serial_Data_In,
  input  logic                  Data_Ready_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Data_Valid_Out,
  output logic                  Busy_Out,
  output logic [CW-1:0]         Bit_Count_Out,
  output logic                  Overrun_Out,
  output logic                  Parity_Error_Out
);

`ifdef USR_RX_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, RECEIVE, HOLD, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECEIVE, HOLD} state_t;
`endif

  state_t                  state, state_next;
  logic                    dir;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_shifted;
  logic                    bit_take;
  logic                    last_bit;
  logic                    handshake;
  logic                    load_start;
  logic                    word_done;
  logic [DATA_WIDTH-1:0]   word_value;

  // Datapath decode shared by the FSM and the registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bit_take      = (state == RECEIVE) && Serial_Valid_In;
    shreg_shifted = dir ? {Serial_Data_In, shreg[DATA_WIDTH-1:1]}
                        : {shreg[DATA_WIDTH-2:0], Serial_Data_In};
    last_bit      = bit_take && (Bit_Count_Out == CW'(DATA_WIDTH - 1));
    handshake     = (state == HOLD) && Data_Ready_In;
    load_start    = Start_In && ((state == IDLE) || handshake);
`ifdef USR_RX_PARITY_CHECK_EN
    word_done     = (state == PARITY) && Serial_Valid_In;
    word_value    = shreg;
`else
    word_done     = last_bit;
    word_value    = shreg_shifted;
`endif
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start_In) state_next = RECEIVE;
`ifdef USR_RX_PARITY_CHECK_EN
      RECEIVE: if (last_bit) state_next = PARITY;
      PARITY:  if (Serial_Valid_In) state_next = HOLD;
`else
      RECEIVE: if (last_bit) state_next = HOLD;
`endif
      HOLD:    if (handshake) state_next = Start_In ? RECEIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset_In) state <= IDLE;
    else          state <= state_next;
  end

  // The shift register is reset alongside the output word so a frame never starts from stale bits.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      dir               <= 1'b0;
      shreg             <= '0;
      Parallel_Data_Out <= '0;
      Data_Valid_Out    <= 1'b0;
      Busy_Out          <= 1'b0;
      Bit_Count_Out     <= '0;
      Overrun_Out       <= 1'b0;
    end else begin
      Busy_Out <= (state_next != IDLE);

      if (load_start) dir <= Shift_Direction_In;
      if (bit_take)   shreg <= shreg_shifted;

      if (load_start || handshake) Bit_Count_Out <= '0;
      else if (bit_take)           Bit_Count_Out <= Bit_Count_Out + CW'(1);

      if (word_done) begin
        Parallel_Data_Out <= word_value;
        Data_Valid_Out    <= 1'b1;
      end else if (handshake) begin
        Data_Valid_Out    <= 1'b0;
      end

      // A bit arriving while a word is still held is lost; remember that until reset.
      if ((state == HOLD) && Serial_Valid_In) Overrun_Out <= 1'b1;
    end
  end

`ifdef USR_RX_PARITY_CHECK_EN
  always_ff @(posedge Clk_In) begin
    if (Reset_In)       Parity_Error_Out <= 1'b0;
    else if (word_done) Parity_Error_Out <= (^shreg) ^ Serial_Data_In;
    else if (handshake) Parity_Error_Out <= 1'b0;
  end
`else
  assign Parity_Error_Out = 1'b0;
`endif

endmodule

// File: doc/usr_serial_byte_receiver.md
Name: usr_serial_byte_receiver

Overview:
Serial-to-parallel receiver for the far end of a universal shift register's serial output. It takes one bit per qualified clock from either the left-shift output (MSB first) or the right-shift output (LSB first) and reassembles a DATA_WIDTH word. It presents the word on a valid/ready handshake and flags overrun. It sits between a USR serial link and a parallel consumer.

Parameters:
DATA_WIDTH, 8, word length in bits (>= 2)

Ports:
Clk_In  input  1  clock; all logic on rising edge
Reset_In  input  1  synchronous, active-high reset
Start_In  input  1  begin a new frame (one-cycle pulse)
Shift_Direction_In  input  1  0 = MSB first (USR shift-left stream), 1 = LSB first (USR shift-right stream); sampled with Start_In
Serial_Valid_In  input  1  Serial_Data_In is a valid bit this cycle
Serial_Data_In  input  1  serial data bit
Data_Ready_In  input  1  consumer accepts the word
Parallel_Data_Out  output  DATA_WIDTH  last completed word
Data_Valid_Out  output  1  word available
Busy_Out  output  1  state != IDLE
Bit_Count_Out  output  $clog2(DATA_WIDTH+1)  bits captured in the current frame
Overrun_Out  output  1  sticky: a bit arrived while a word was held
Parity_Error_Out  output  1  see Optional Feature

Behaviour:
- Reset (synchronous, Reset_In=1 at a rising edge): state IDLE, all outputs 0, internal shift register 0, latched direction 0. Reset wins over every other input, including mid-frame.
- States: IDLE, RECEIVE, HOLD (plus PARITY with the macro).
- IDLE:
  - Start_In=1: latch Shift_Direction_In, clear the count, go to RECEIVE.
  - Serial_Valid_In is ignored in IDLE, including in the same cycle as Start_In.
- RECEIVE, each cycle with Serial_Valid_In=1:
  - MSB first: shreg <= {shreg[W-2:0], bit}.
  - LSB first: shreg <= {bit, shreg[W-1:1]}.
  - Bit_Count_Out increments by 1.
  - Cycles with Serial_Valid_In=0 hold all state. Start_In is ignored.
- Completion: on the edge that captures bit W, load Parallel_Data_Out with the assembled word, set Data_Valid_Out=1, Bit_Count_Out=W, go to HOLD. Data_Valid_Out is visible the cycle after the last valid bit (latency 1).
- HOLD:
  - Data_Valid_Out=1 and Parallel_Data_Out stable until Data_Valid_Out && Data_Ready_In.
  - On that handshake: next cycle Data_Valid_Out=0, Bit_Count_Out=0, state IDLE.
  - Handshake plus Start_In in the same cycle: go directly to RECEIVE with the new direction latched. No IDLE bubble.
  - Serial_Valid_In=1 in HOLD: bit discarded, Overrun_Out set. It stays 1 until reset.
- Parallel_Data_Out keeps the last word after the handshake until the next word completes. The internal shift register is separate from the output register.
- Busy_Out is registered and equals (state != IDLE).

Optional Feature:
Macro: USR_RX_PARITY_CHECK_EN
- Defined:
  - After bit W, enter PARITY (Data_Valid_Out still 0, Busy_Out 1).
  - The next valid bit is the even-parity bit. On capture: Parallel_Data_Out, Data_Valid_Out=1, and Parity_Error_Out = (^word) ^ parity_bit, all in the same edge; then go to HOLD.
  - Parity_Error_Out is cleared with the handshake.
  - Bit_Count_Out counts only data bits (saturates at W).
- Undefined: no PARITY state; Parity_Error_Out is tied 0.

Test Plan:
1. Reset; Start_In with Shift_Direction_In=0; bits 1,0,1,1,0,0,1,0 on consecutive cycles -> Data_Valid_Out=1 the cycle after bit 8, Parallel_Data_Out=8'hB2, Bit_Count_Out=8, Busy_Out=1.
2. Same bit sequence with Shift_Direction_In=1 -> Parallel_Data_Out=8'h4D.
3. 8'hA5 MSB first with Serial_Valid_In every other cycle, Data_Ready_In=1 -> Bit_Count_Out steps only on valid cycles; word 8'hA5; Data_Valid_Out high for exactly 1 cycle, then IDLE.
4. Complete 8'hB2, hold Data_Ready_In=0 for 5 cycles, pulse Serial_Valid_In once -> Overrun_Out=1 and sticky, Parallel_Data_Out stays 8'hB2. Then raise Data_Ready_In -> Data_Valid_Out=0 next cycle, data remains 8'hB2.
5. Handshake and Start_In (direction 0) in the same cycle, then stream 8'h3C -> no IDLE cycle (Busy_Out stays 1), second word 8'h3C. Separately: Reset_In after 4 bits of a frame -> next cycle all outputs 0 and IDLE; a fresh 8'h5A frame is received correctly.
6. With USR_RX_PARITY_CHECK_EN: 8'hB2 + parity bit 0 -> Parity_Error_Out=0; 8'hB2 + parity bit 1 -> Parity_Error_Out=1, asserted together with Data_Valid_Out.
